matmul_tile_scheduler: RTL
==========================

Name: matmul_tile_scheduler

Overview:
- Sequencing controller for the multi-core systolic matmul datapath.
- Walks every output tile of C = I x W^T in row-major tile order (column index fastest).
- For each tile it issues the input and weight BRAM port-B read addresses for every inner-dimension step and hands each fetched chunk to the core array.
- It then waits for the accumulated result, offers it downstream with a valid/ready handshake, and clears the accumulator before starting the next tile.

Parameters:
- BLOCK_SIZE, 2: systolic array dimension.
- INNER_DIMENSION, 4: shared dimension. K_STEPS = INNER_DIMENSION/BLOCK_SIZE.
- I_OUTER_DIMENSION, 8: input matrix rows. ROW_TILES = I_OUTER_DIMENSION/(BLOCK_SIZE*NUM_CORES).
- W_OUTER_DIMENSION, 6: weight matrix rows. COL_TILES = W_OUTER_DIMENSION/BLOCK_SIZE.
- NUM_CORES, 2: parallel cores; each input BRAM word feeds all of them.
- ADDR_WIDTH_I, 3: input BRAM address width.
- ADDR_WIDTH_W, 3: weight BRAM address width.
- CNT_WIDTH, 16: width of the tile counters and of tiles_done.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a full matrix pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses
- done  out  1  one-cycle pulse when all tiles have been delivered
- in_enb  out  1  input BRAM port-B enable
- in_addrb  out  ADDR_WIDTH_I  input BRAM port-B address
- wb_enb  out  1  weight BRAM port-B enable
- wb_addrb  out  ADDR_WIDTH_W  weight BRAM port-B address
- core_en  out  1  core enable; high in FETCH, LOAD, WAIT_STEP and WAIT_ACC
- core_load  out  1  one-cycle pulse: BRAM outputs are valid for the core
- core_step_done  in  1  pulse: core has consumed the current chunk
- core_acc_valid  in  1  pulse: accumulated tile result is valid on the core outputs
- acc_clr  out  1  one-cycle accumulator clear
- out_valid  out  1  tile result available
- out_ready  in  1  downstream accepts the tile result
- out_row  out  CNT_WIDTH  row-tile index of the offered result
- out_col  out  CNT_WIDTH  column-tile index of the offered result
- tiles_done  out  CNT_WIDTH  number of tiles accepted in the current pass
- protocol_err  out  1  sticky; set on an unexpected core pulse

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset applied mid-pass aborts immediately; no done pulse is generated. protocol_err clears only on rst.
- All outputs are registered.
- Counters: k (0..K_STEPS-1), row (0..ROW_TILES-1), col (0..COL_TILES-1).
- Addressing: in_addrb = k + K_STEPS*row; wb_addrb = k + K_STEPS*col. Both are computed from the counters that are current in the FETCH cycle.
- IDLE:
  - start=1 -> FETCH.
  - Counters and tiles_done are zeroed on entry to FETCH.
  - start while not in IDLE is ignored.
- FETCH (1 cycle): in_enb=wb_enb=1 with addresses valid -> LOAD.
- LOAD (1 cycle): BRAM data valid (read latency 1); core_load=1 -> WAIT_STEP.
- WAIT_STEP: wait for core_step_done.
  - If k<K_STEPS-1: k++ -> FETCH.
  - Otherwise: k=0 -> WAIT_ACC.
  - The minimum step period is 3 cycles.
- WAIT_ACC: wait for core_acc_valid -> OUTPUT.
  - A core_acc_valid in the same cycle as the final core_step_done is latched into a sticky flag and consumed on WAIT_ACC entry, so WAIT_ACC lasts 1 cycle.
- OUTPUT: out_valid=1 while out_row/out_col are held stable.
  - The transfer occurs in any cycle with out_valid&&out_ready, including the first OUTPUT cycle.
  - On transfer: out_valid=0, tiles_done++ -> CLEAR.
- CLEAR (1 cycle): acc_clr=1 and the tile index advances (col++; at COL_TILES-1, col=0 and row++).
  - Last tile (row=ROW_TILES-1, col=COL_TILES-1) -> DONE.
  - Otherwise -> FETCH.
- DONE (1 cycle): done=1, busy drops in the same cycle -> IDLE. tiles_done holds its value until the next start.
- protocol_err is set by:
  - core_step_done outside WAIT_STEP (except the latched-acc case above), or
  - core_acc_valid outside WAIT_STEP/WAIT_ACC.
- The offending pulse is otherwise ignored and the FSM does not change state.
- Total tiles = ROW_TILES*COL_TILES. Width rules: all arithmetic is unsigned, and addresses are truncated to ADDR_WIDTH.

Test Plan:
- Defaults, core returns core_step_done 1 cycle after core_load, core_acc_valid 2 cycles after the last step, out_ready tied 1 -> in_addrb sequence 0,1,0,1,0,1,2,3,2,3,2,3; wb_addrb sequence 0,1,2,3,4,5,0,1,2,3,4,5; exactly 6 acc_clr pulses; tiles_done=6; a single done pulse; protocol_err=0.
- Backpressure: out_ready held 0 for 5 cycles on tile (0,1) -> out_valid stays high with out_row=0, out_col=1; no BRAM enables during the stall; transfer occurs on the first out_ready=1 cycle.
- core_acc_valid coincident with the final core_step_done -> WAIT_ACC lasts 1 cycle; no hang; protocol_err=0.
- start pulsed again while busy, and core_step_done injected in IDLE -> the pass is unaffected; protocol_err=1 and stays 1 until rst.
- rst asserted during WAIT_STEP of tile 3 -> the next cycle shows all outputs 0 and state IDLE; no done pulse; a new start completes all 6 tiles beginning at address 0.
- Back-to-back passes, with start asserted in the cycle after done -> the second pass produces an identical address trace and tiles_done restarts from 0.

Source files
------------

// File: rtl/matmul_tile_scheduler.sv
// Tile sequencer for the systolic matmul datapath. It walks every output tile
// in row-major order, issues the BRAM reads for each inner-dimension step,
// waits for the accumulated tile, and hands it downstream with valid/ready.
module matmul_tile_scheduler #(
    parameter int BLOCK_SIZE        = 2,
    parameter int INNER_DIMENSION   = 4,
    parameter int I_OUTER_DIMENSION = 8,
    parameter int W_OUTER_DIMENSION = 6,
    parameter int NUM_CORES         = 2,
    parameter int ADDR_WIDTH_I      = 3,
    parameter int ADDR_WIDTH_W      = 3,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    in_enb,
    output logic [ADDR_WIDTH_I-1:0] in_addrb,
    output logic                    wb_enb,
    output logic [ADDR_WIDTH_W-1:0] wb_addrb,
    output logic                    core_en,
    output logic                    core_load,
    input  logic                    core_step_done,
    input  logic                    core_acc_valid,
    output logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_WIDTH-1:0]    out_row,
    output logic [CNT_WIDTH-1:0]    out_col,
    output logic [CNT_WIDTH-1:0]    tiles_done,
    output logic                    protocol_err
);

    localparam int K_STEPS   = INNER_DIMENSION / BLOCK_SIZE;
    localparam int ROW_TILES = I_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES);
    localparam int COL_TILES = W_OUTER_DIMENSION / BLOCK_SIZE;

    localparam logic [CNT_WIDTH-1:0] K_LAST   = CNT_WIDTH'(K_STEPS - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(ROW_TILES - 1);
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(COL_TILES - 1);
    localparam logic [CNT_WIDTH-1:0] K_MUL    = CNT_WIDTH'(K_STEPS);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT_STEP,
        S_WAIT_ACC,
        S_OUTPUT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    k_q, k_d;
    logic [CNT_WIDTH-1:0]    row_q, row_d;
    logic [CNT_WIDTH-1:0]    col_q, col_d;
    logic [CNT_WIDTH-1:0]    tiles_q, tiles_d;
    logic                    acc_seen_q, acc_seen_d;
    logic                    err_q, err_d;

    logic                    busy_q, done_q, in_enb_q, wb_enb_q;
    logic                    core_en_q, core_load_q, acc_clr_q, out_valid_q;
    logic [ADDR_WIDTH_I-1:0] in_addrb_q;
    logic [ADDR_WIDTH_W-1:0] wb_addrb_q;

    // Next-state, counter and error-flag logic.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        row_d      = row_q;
        col_d      = col_q;
        tiles_d    = tiles_q;
        acc_seen_d = acc_seen_q;
        err_d      = err_q;

        // Stray core pulses only raise the sticky error; the FSM ignores them.
        if (core_step_done && state_q != S_WAIT_STEP) begin
            err_d = 1'b1;
        end
        if (core_acc_valid && state_q != S_WAIT_STEP && state_q != S_WAIT_ACC) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    k_d        = '0;
                    row_d      = '0;
                    col_d      = '0;
                    tiles_d    = '0;
                    acc_seen_d = 1'b0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_WAIT_STEP;
            S_WAIT_STEP: begin
                if (core_step_done) begin
                    if (k_q != K_LAST) begin
                        k_d     = k_q + ONE;
                        state_d = S_FETCH;
                    end else begin
                        k_d        = '0;
                        state_d    = S_WAIT_ACC;
                        // Result may arrive together with the last step.
                        acc_seen_d = core_acc_valid;
                    end
                end
            end
            S_WAIT_ACC: begin
                if (acc_seen_q || core_acc_valid) begin
                    acc_seen_d = 1'b0;
                    state_d    = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    tiles_d = tiles_q + ONE;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (row_q == ROW_LAST && col_q == COL_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ONE;
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            tiles_q     <= '0;
            acc_seen_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_enb_q    <= 1'b0;
            wb_enb_q    <= 1'b0;
            in_addrb_q  <= '0;
            wb_addrb_q  <= '0;
            core_en_q   <= 1'b0;
            core_load_q <= 1'b0;
            acc_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tiles_q     <= tiles_d;
            acc_seen_q  <= acc_seen_d;
            err_q       <= err_d;
            busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q      <= (state_d == S_DONE);
            in_enb_q    <= (state_d == S_FETCH);
            wb_enb_q    <= (state_d == S_FETCH);
            if (state_d == S_FETCH) begin
                in_addrb_q <= ADDR_WIDTH_I'(k_d + K_MUL * row_d);
                wb_addrb_q <= ADDR_WIDTH_W'(k_d + K_MUL * col_d);
            end
            core_en_q   <= (state_d == S_FETCH) || (state_d == S_LOAD) ||
                           (state_d == S_WAIT_STEP) || (state_d == S_WAIT_ACC);
            core_load_q <= (state_d == S_LOAD);
            acc_clr_q   <= (state_d == S_CLEAR);
            out_valid_q <= (state_d == S_OUTPUT);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign in_enb       = in_enb_q;
    assign in_addrb     = in_addrb_q;
    assign wb_enb       = wb_enb_q;
    assign wb_addrb     = wb_addrb_q;
    assign core_en      = core_en_q;
    assign core_load    = core_load_q;
    assign acc_clr      = acc_clr_q;
    assign out_valid    = out_valid_q;
    assign out_row      = row_q;
    assign out_col      = col_q;
    assign tiles_done   = tiles_q;
    assign protocol_err = err_q;

endmodule
